instr_fetch: RTL

//  Fetch stage ahead of the decoder. Holds the PC and issues in-order word reads to instruction memory.

---
 rtl/instr_fetch.sv | 98 +++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven in-order instruction fetch with credit-limited FIFO and redirect flush
module instr_fetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               QDEPTH   = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {IDLE, RUN} phase_t;
  phase_t           phase_q, phase_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, inst_q, inst_d, inst_pc_q, inst_pc_d, tgt;
  logic [CW-1:0]    inflight_q, inflight_d, drop_q, drop_d, count_q, count_d;
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_data_q [QDEPTH];
  logic [WIDTH-1:0] mem_data_d [QDEPTH];
  logic [WIDTH-1:0] mem_pc_q [QDEPTH];
  logic [WIDTH-1:0] mem_pc_d [QDEPTH];
  logic             acc, push, pop;
  always_comb begin
    imem_req_valid = phase_q == RUN && !redirect_valid &&
                     ({1'b0, inflight_q} + {1'b0, count_q}) < (CW + 1)'(QDEPTH);
    imem_req_addr  = fetch_pc_q;
    inst_valid     = count_q != '0;
    inst           = inst_q;
    inst_pc        = inst_pc_q;
    tgt            = redirect_pc & ~WIDTH'(3);
    acc            = imem_req_valid && imem_req_ready;
    push           = imem_rsp_valid && !redirect_valid && drop_q == '0;
    pop            = inst_valid && inst_ready && !redirect_valid;
    phase_d        = RUN;
    fetch_pc_d     = acc ? fetch_pc_q + WIDTH'(4) : fetch_pc_q;
    rsp_pc_d       = push ? rsp_pc_q + WIDTH'(4) : rsp_pc_q;
    inflight_d     = inflight_q + CW'(acc) - CW'(imem_rsp_valid);
    drop_d         = imem_rsp_valid && drop_q != '0 ? drop_q - CW'(1) : drop_q;
    count_d        = count_q + CW'(push) - CW'(pop);
    wr_d           = wr_q + PW'(push);
    rd_d           = rd_q + PW'(pop);
    mem_data_d     = mem_data_q;
    mem_pc_d       = mem_pc_q;
    if (push) begin
      mem_data_d[wr_q] = imem_rsp_data;
      mem_pc_d[wr_q]   = rsp_pc_q;
    end
    if (redirect_valid) begin
      fetch_pc_d = tgt;
      rsp_pc_d   = tgt;
      drop_d     = inflight_q - CW'(imem_rsp_valid);
      count_d    = '0;
      wr_d       = '0;
      rd_d       = '0;
    end
    inst_d    = count_d != '0 ? mem_data_d[rd_d] : '0;
    inst_pc_d = count_d != '0 ? mem_pc_d[rd_d] : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      mem_data_q <= '{default: '0};
      mem_pc_q   <= '{default: '0};
    end else begin
      phase_q    <= phase_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      mem_data_q <= mem_data_d;
      mem_pc_q   <= mem_pc_d;
    end
  end
endmodule
